// File: rtl/tx_am_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tx_am_scheduler                                                            |
// | Inserts 40GBASE-R alignment-marker groups into the 66-bit block stream.    |
// | It throttles the source and tracks per-lane BIP across an 8-entry skid FIFO.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tx_am_scheduler #(
  parameter int AM_INTERVAL = 16384,
  parameter int PAUSE_LEAD  = 2
) (
  input  logic        TX_CLK,
  input  logic        reset,
  input  logic [65:0] in_block,
  input  logic        in_valid,
  input  logic        am_enable,
  output logic        tx_pause,
  output logic [65:0] out_block,
  output logic        out_valid,
  output logic        out_am,
  output logic [1:0]  out_lane,
  output logic [3:0]  fifo_level,
  output logic        fifo_ovf,
  output logic        fifo_unf
);

  localparam int c_period = 4 * AM_INTERVAL;
  localparam int c_cw     = $clog2(c_period);
  localparam int c_aw     = c_cw + 1;
  localparam logic [c_cw-1:0] c_cnt_max  = c_cw'(c_period - 1);
  localparam logic [c_cw-1:0] c_arm_slot = c_cw'((c_period - PAUSE_LEAD) % c_period);

  logic [c_cw-1:0] r_cnt;
  logic            r_am_armed;
  logic [65:0]     r_mem [8];
  logic [2:0]      r_rd_ptr;
  logic [2:0]      r_wr_ptr;
  logic [3:0]      r_level;
  logic [65:0]     r_out_block;
  logic            r_out_valid;
  logic            r_out_am;
  logic [1:0]      r_out_lane;
  logic            r_ovf;
  logic            r_unf;
  logic [7:0]      r_bip [4];

  logic [c_aw-1:0] w_ahead_raw;
  logic [c_aw-1:0] w_ahead;
  logic [1:0]      w_lane;
  logic            w_am_slot;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [65:0]     w_head;
  logic [23:0]     w_m;
  logic [7:0]      w_bip_cur;
  logic [65:0]     w_am_block;

  // Folds a block into the 8-bit BIP: bits 2..65 byte-wise, sync bits onto BIP bits 3 and 4.
  function automatic logic [7:0] f_bip(input logic [65:0] blk);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      p = p ^ blk[8*k+2 +: 8];
    end
    p = p ^ {3'b000, blk[1], blk[0], 3'b000};
    return p;
  endfunction

  // Pause window is the AM group seen PAUSE_LEAD slots early, modulo the period.
  assign w_ahead_raw = {1'b0, r_cnt} + c_aw'(PAUSE_LEAD);
  assign w_ahead     = (w_ahead_raw >= c_aw'(c_period)) ? (w_ahead_raw - c_aw'(c_period))
                                                         : w_ahead_raw;
  assign tx_pause    = r_am_armed && (w_ahead < c_aw'(4));

  assign w_lane    = r_cnt[1:0];
  assign w_am_slot = r_am_armed && (r_cnt < c_cw'(4));
  assign w_head    = r_mem[r_rd_ptr];
  assign w_pop     = !w_am_slot && (r_level != 4'd0);
  assign w_push    = in_valid && ((r_level != 4'd8) || w_pop);
  assign w_drop    = in_valid && !w_push;

  always_comb begin
    w_m = 24'h000000;
    case (w_lane)
      2'd0:    w_m = {8'h47, 8'h76, 8'h90};
      2'd1:    w_m = {8'hE6, 8'hC4, 8'hF0};
      2'd2:    w_m = {8'h9B, 8'h65, 8'hC5};
      default: w_m = {8'h3D, 8'h79, 8'hA2};
    endcase
  end

  assign w_bip_cur  = r_bip[w_lane];
  assign w_am_block = {~w_bip_cur, ~w_m, w_bip_cur, w_m, 2'b01};

  always_ff @(posedge TX_CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_block;
    end
  end

  always_ff @(posedge TX_CLK or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_am_armed  <= 1'b0;
      r_rd_ptr    <= 3'd0;
      r_wr_ptr    <= 3'd0;
      r_level     <= 4'd0;
      r_out_block <= 66'h0;
      r_out_valid <= 1'b0;
      r_out_am    <= 1'b0;
      r_out_lane  <= 2'd0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_bip[i] <= 8'h00;
      end
    end else begin
      r_cnt      <= (r_cnt == c_cnt_max) ? '0 : r_cnt + c_cw'(1);
      r_out_lane <= w_lane;
      if (r_cnt == c_arm_slot) begin
        r_am_armed <= am_enable;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 3'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 3'd1;
      end
      r_level <= r_level + {3'b000, w_push} - {3'b000, w_pop};
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      // The AM itself seeds the next interval's BIP for its lane.
      if (w_am_slot) begin
        r_out_block   <= w_am_block;
        r_out_valid   <= 1'b1;
        r_out_am      <= 1'b1;
        r_bip[w_lane] <= f_bip(w_am_block);
      end else if (w_pop) begin
        r_out_block   <= w_head;
        r_out_valid   <= 1'b1;
        r_out_am      <= 1'b0;
        r_bip[w_lane] <= w_bip_cur ^ f_bip(w_head);
      end else begin
        r_out_valid <= 1'b0;
        r_out_am    <= 1'b0;
        r_unf       <= 1'b1;
      end
    end
  end

  assign out_block  = r_out_block;
  assign out_valid  = r_out_valid;
  assign out_am     = r_out_am;
  assign out_lane   = r_out_lane;
  assign fifo_level = r_level;
  assign fifo_ovf   = r_ovf;
  assign fifo_unf   = r_unf;

endmodule
`default_nettype wire
